// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM high-time and period capture with stuck-input detection
// Measurements are taken from the synchronized copy of pwm_in only.
module pwm_capture #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] high_cnt,
    output logic [WIDTH-1:0] period,
    output logic             valid,
    output logic             stuck_high,
    output logic             stuck_low
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    state_t           r_state;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_s_d;
    logic [WIDTH-1:0] r_period_run;
    logic [WIDTH-1:0] r_high_run;
    logic [WIDTH-1:0] r_high_cnt;
    logic [WIDTH-1:0] r_period;
    logic             r_valid;
    logic             r_stuck_high;
    logic             r_stuck_low;

    logic w_s;
    logic w_rise;
    logic w_timeout;

    assign w_s       = r_sync2;
    assign w_rise    = r_sync2 & ~r_s_d;
    assign w_timeout = (r_period_run == ALL_ONES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_s_d   <= 1'b0;
        end else begin
            r_sync1 <= pwm_in;
            r_sync2 <= r_sync1;
            r_s_d   <= r_sync2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_period_run <= '0;
            r_high_run   <= '0;
            r_high_cnt   <= '0;
            r_period     <= '0;
            r_valid      <= 1'b0;
            r_stuck_high <= 1'b0;
            r_stuck_low  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_rise) begin
                // The rise cycle itself is the first cycle of the next period.
                if (r_state == MEASURE) begin
                    r_period   <= r_period_run;
                    r_high_cnt <= r_high_run;
                    r_valid    <= 1'b1;
                end
                r_state      <= MEASURE;
                r_period_run <= ONE;
                r_high_run   <= ONE;
                r_stuck_high <= 1'b0;
                r_stuck_low  <= 1'b0;
            end else if (w_timeout) begin
                r_state      <= IDLE;
                r_period_run <= '0;
                r_high_run   <= '0;
                r_stuck_high <= w_s;
                r_stuck_low  <= ~w_s;
                r_high_cnt   <= w_s ? ALL_ONES : '0;
                r_period     <= ALL_ONES;
            end else begin
                r_period_run <= r_period_run + ONE;
                if ((r_state == MEASURE) && w_s) begin
                    r_high_run <= r_high_run + ONE;
                end
            end
        end
    end

    assign high_cnt   = r_high_cnt;
    assign period     = r_period;
    assign valid      = r_valid;
    assign stuck_high = r_stuck_high;
    assign stuck_low  = r_stuck_low;

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - directed self-checking bench for pwm_capture
module tb_pwm_capture;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pwm16 = 1'b0;
    logic pwm8 = 1'b0;

    logic [15:0] hc16, per16;
    logic        v16, sh16, sl16;
    logic [7:0]  hc8, per8;
    logic        v8, sh8, sl8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pwm_capture #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .pwm_in(pwm16),
        .high_cnt(hc16), .period(per16), .valid(v16),
        .stuck_high(sh16), .stuck_low(sl16)
    );

    pwm_capture #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .pwm_in(pwm8),
        .high_cnt(hc8), .period(per8), .valid(v8),
        .stuck_high(sh8), .stuck_low(sl8)
    );

    task automatic do_reset();
        rst_n = 1'b0;
        pwm16 = 1'b0;
        pwm8  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pwm16 = 1'b0;
        pwm8  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({v16, sh16, sl16, hc16, per16} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset16 got v=%b sh=%b sl=%b hc=%0d per=%0d required all 0", v16, sh16, sl16, hc16, per16);
        end
        n_checks++;
        if ({v8, sh8, sl8, hc8, per8} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset8 got v=%b sh=%b sl=%b hc=%0d per=%0d required all 0", v8, sh8, sl8, hc8, per8);
        end
        rst_n = 1'b1;
    endtask

    // Square wave on dut16: after `lead` low cycles, h high out of every p cycles.
    task automatic test_duty(input string name, input int lead, input int h, input int p, input int nper);
        logic        exp_v;
        logic [15:0] exp_hc;
        logic [15:0] exp_per;
        do_reset();
        exp_hc  = '0;
        exp_per = '0;
        for (int c = 0; c < lead + nper * p + 3; c++) begin
            pwm16 = (c >= lead) && (((c - lead) % p) < h);
            @(posedge clk);
            #1;
            exp_v = (c - lead - 2 >= p) && (((c - lead - 2) % p) == 0);
            if (exp_v) begin
                exp_hc  = 16'(h);
                exp_per = 16'(p);
            end
            n_checks++;
            if (v16 !== exp_v) begin
                n_fail++;
                $display("FAIL %s valid c=%0d got %b required %b", name, c, v16, exp_v);
            end
            n_checks++;
            if (hc16 !== exp_hc) begin
                n_fail++;
                $display("FAIL %s high_cnt c=%0d got %0d required %0d", name, c, hc16, exp_hc);
            end
            n_checks++;
            if (per16 !== exp_per) begin
                n_fail++;
                $display("FAIL %s period c=%0d got %0d required %0d", name, c, per16, exp_per);
            end
            n_checks++;
            if ({sh16, sl16} !== 2'b00) begin
                n_fail++;
                $display("FAIL %s stuck c=%0d got %b%b required 00", name, c, sh16, sl16);
            end
        end
    endtask

    task automatic test_stuck_high();
        logic       exp_v, exp_sh;
        logic [7:0] exp_hc, exp_per;
        do_reset();
        for (int c = 0; c < 460; c++) begin
            pwm8 = (c < 100) ? ((c % 50) < 20) :
                   (c < 380) ? 1'b1 :
                   (c < 390) ? 1'b0 :
                   (c < 410) ? 1'b1 :
                   (c < 450) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
            exp_v   = (c == 52) || (c == 102) || (c == 452);
            exp_sh  = (c >= 357) && (c < 392);
            exp_hc  = (c < 52) ? 8'd0 : (c < 357) ? 8'd20 : (c < 452) ? 8'd255 : 8'd20;
            exp_per = (c < 52) ? 8'd0 : (c < 357) ? 8'd50 : (c < 452) ? 8'd255 : 8'd60;
            n_checks++;
            if (v8 !== exp_v) begin
                n_fail++;
                $display("FAIL stuck_high valid c=%0d got %b required %b", c, v8, exp_v);
            end
            n_checks++;
            if ({sh8, sl8} !== {exp_sh, 1'b0}) begin
                n_fail++;
                $display("FAIL stuck_high flags c=%0d got %b%b required %b0", c, sh8, sl8, exp_sh);
            end
            n_checks++;
            if ({hc8, per8} !== {exp_hc, exp_per}) begin
                n_fail++;
                $display("FAIL stuck_high outputs c=%0d got hc=%0d per=%0d required hc=%0d per=%0d", c, hc8, per8, exp_hc, exp_per);
            end
        end
    endtask

    task automatic test_stuck_low();
        logic       exp_v, exp_sl;
        logic [7:0] exp_hc, exp_per;
        do_reset();
        for (int c = 0; c < 650; c++) begin
            pwm8 = (c >= 300 && c < 390) ? (((c - 300) % 40) < 10) : 1'b0;
            @(posedge clk);
            #1;
            exp_v   = (c == 342) || (c == 382);
            exp_sl  = ((c >= 255) && (c < 302)) || (c >= 637);
            exp_hc  = ((c >= 342) && (c < 637)) ? 8'd10 : 8'd0;
            exp_per = (c < 255) ? 8'd0 : (c < 342) ? 8'd255 : (c < 637) ? 8'd40 : 8'd255;
            n_checks++;
            if (v8 !== exp_v) begin
                n_fail++;
                $display("FAIL stuck_low valid c=%0d got %b required %b", c, v8, exp_v);
            end
            n_checks++;
            if ({sh8, sl8} !== {1'b0, exp_sl}) begin
                n_fail++;
                $display("FAIL stuck_low flags c=%0d got %b%b required 0%b", c, sh8, sl8, exp_sl);
            end
            n_checks++;
            if ({hc8, per8} !== {exp_hc, exp_per}) begin
                n_fail++;
                $display("FAIL stuck_low outputs c=%0d got hc=%0d per=%0d required hc=%0d per=%0d", c, hc8, per8, exp_hc, exp_per);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic        exp_v;
        logic [15:0] exp_hc, exp_per;
        do_reset();
        for (int c = 0; c < 150; c++) begin
            pwm16 = ((c % 100) < 30);
            @(posedge clk);
            #1;
        end
        n_checks++;
        if ({hc16, per16} !== {16'd30, 16'd100}) begin
            n_fail++;
            $display("FAIL reset_mid pre got hc=%0d per=%0d required hc=30 per=100", hc16, per16);
        end
        rst_n = 1'b0;
        #2;
        n_checks++;
        if ({v16, sh16, sl16, hc16, per16} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_mid async got v=%b sh=%b sl=%b hc=%0d per=%0d required all 0", v16, sh16, sl16, hc16, per16);
        end
        pwm16 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 170; c++) begin
            pwm16 = (c >= 5) && (((c - 5) % 80) < 40);
            @(posedge clk);
            #1;
            exp_v   = (c == 87) || (c == 167);
            exp_hc  = (c < 87) ? 16'd0 : 16'd40;
            exp_per = (c < 87) ? 16'd0 : 16'd80;
            n_checks++;
            if (v16 !== exp_v) begin
                n_fail++;
                $display("FAIL reset_mid valid c=%0d got %b required %b", c, v16, exp_v);
            end
            n_checks++;
            if ({hc16, per16} !== {exp_hc, exp_per}) begin
                n_fail++;
                $display("FAIL reset_mid outputs c=%0d got hc=%0d per=%0d required hc=%0d per=%0d", c, hc16, per16, exp_hc, exp_per);
            end
        end
    endtask

    initial begin
        test_reset();
        test_duty("steady_30_100", 10, 30, 100, 5);
        test_duty("duty_1_100", 10, 1, 100, 3);
        test_duty("duty_99_100", 10, 99, 100, 3);
        test_duty("latency", 300, 50, 100, 2);
        test_stuck_high();
        test_stuck_low();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the width of the measurement counters and outputs.
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port pwm_in  input  1  PWM waveform to measure, asynchronous to clk.
REQ-005 SHALL have port high_cnt  output  WIDTH  last measured high time, in clk cycles.
REQ-006 SHALL have port period  output  WIDTH  last measured period, in clk cycles.
REQ-007 SHALL have port valid  output  1  one-cycle pulse when high_cnt and period are updated.
REQ-008 SHALL have port stuck_high  output  1  pwm_in held high with no rising edge for 2^WIDTH-1 cycles.
REQ-009 SHALL have port stuck_low  output  1  pwm_in held low with no rising edge for 2^WIDTH-1 cycles.

Function
REQ-010 SHALL pass pwm_in through a 2-flop synchronizer; s denotes the second flop output and s_d a further delayed copy.
REQ-011 SHALL define rise = s AND NOT s_d; all measurements SHALL use s only, never raw pwm_in.
REQ-012 SHALL implement a 2-state FSM: IDLE (no reference edge yet) and MEASURE (counting since last rise).
REQ-013 IDLE: on rise -> MEASURE, load period_run=1 and high_run=1, pulse no valid.
REQ-014 MEASURE, non-rise cycle: period_run increments by 1; high_run increments by 1 when s=1, holds when s=0.
REQ-015 MEASURE, rise cycle: on the next clk edge, period<=period_run, high_cnt<=high_run, valid<=1, then period_run and high_run reload to 1, FSM stays MEASURE.
REQ-016 For a waveform of exactly H high cycles in a P-cycle period, 1<=H<P, outputs SHALL read exactly high_cnt=H and period=P.
REQ-017 valid SHALL be high for exactly one cycle per measurement, deasserted in all other cycles.
REQ-018 Latency: valid SHALL assert after the third clk rising edge counting the edge that first samples pwm_in high (2 sync stages + 1 output register).
REQ-019 high_cnt and period SHALL hold their values between valid pulses.
REQ-020 Timeout: when period_run reaches 2^WIDTH-1 in MEASURE without a rise, FSM SHALL go to IDLE, no valid pulse, and on that same edge stuck_high<=s and stuck_low<=NOT s.
REQ-021 Timeout update: high_cnt<=all-ones if s=1, else 0; period<=all-ones.
REQ-022 IDLE SHALL also time out after 2^WIDTH-1 cycles without rise, with the same flag behaviour, using period_run as the idle counter.
REQ-023 stuck_high and stuck_low SHALL be mutually exclusive and SHALL clear on the clk edge that registers the next rise.
REQ-024 Counters SHALL never wrap; the timeout at all-ones pre-empts overflow.
REQ-025 Glitches shorter than one clk period may be missed; any pulse that s captures SHALL be measured as real.

Reset
REQ-026 While rst_n=0, all of the following SHALL be 0 immediately, independent of clk: synchronizer flops, s_d, counters, FSM (=IDLE), high_cnt, period, valid, stuck_high and stuck_low.
REQ-027 Reset asserted mid-measurement SHALL discard the partial measurement; after release, the first rise SHALL only arm MEASURE (no valid).

Verification
REQ-028 WIDTH=16, pwm_in 30 high/100 period, steady -> first valid on second rise; every valid thereafter has high_cnt=30, period=100, spacing 100 cycles.
REQ-029 Duty sweep H=1 and H=99 at P=100 -> high_cnt=1 and 99 respectively, period=100, one valid per period.
REQ-030 Latency: pwm_in low long after reset, then square wave -> valid exactly 3 edges after the sampling edge of the second rise; check no valid after the first rise.
REQ-031 WIDTH=8, pwm_in held high after activity -> 255 cycles after last rise stuck_high=1, high_cnt=255, period=255, no valid; next rise clears the flag; the following rise gives a correct valid.
REQ-032 WIDTH=8, pwm_in held low -> stuck_low=1, high_cnt=0, period=255; from IDLE after reset with pwm_in low -> stuck_low after 255 cycles.
REQ-033 Assert rst_n=0 mid-period with outputs nonzero -> all outputs 0 without a clk edge; after release the first rise gives no valid, and the second rise gives a correct measurement.
